// File: rtl/nn_output_layer.sv
// Output layer of the binary MNIST network: streams hidden activations, class-major
// weights and biases from SDRAM, accumulates 10 class scores and reports the argmax.
module nn_output_layer #(
  parameter int HIDDEN   = 200,
  parameter int CLASSES  = 10,
  parameter int ACT_BASE = 205000,
  parameter int W_BASE   = 205200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startSig,
  output logic        doneSig,
  output logic        read_n,
  output logic [31:0] address,
  input  logic        waitrequest,
  input  logic        readdatavalid,
  input  logic [15:0] readdata,
  output logic [3:0]  digit,
  output logic [23:0] max_score,
  output logic        busy
);

  localparam int N     = HIDDEN + CLASSES * HIDDEN + CLASSES;
  localparam int W_END = HIDDEN + CLASSES * HIDDEN;
  localparam int CW    = $clog2(N + 1);
  localparam int IW    = $clog2(HIDDEN);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, FINAL, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      issue_cnt;
  logic [CW-1:0]      rx_cnt;
  logic [3:0]         w_cls;
  logic [IW-1:0]      w_in;
  logic [3:0]         fin_k;
  logic [HIDDEN-1:0]  act;
  logic signed [23:0] acc [CLASSES];
  logic signed [23:0] best_score;
  logic [3:0]         best_idx;

  logic [CW-1:0]      issue_nxt;
  logic [31:0]        addr_nxt;
  logic signed [23:0] rd_ext;
  logic               rx_en;
  logic               cand_wins;
  logic signed [23:0] nb_score;
  logic [3:0]         nb_idx;

  assign issue_nxt = issue_cnt + 1'b1;
  assign rd_ext    = {{8{readdata[15]}}, readdata};
  // Responses are only meaningful while a run is fetching; strays in IDLE are dropped.
  assign rx_en     = readdatavalid && (state == ISSUE || state == DRAIN) && (rx_cnt != CW'(N));

  always_comb begin
    addr_nxt = '0;
    if (issue_nxt < CW'(HIDDEN))
      addr_nxt = 32'(ACT_BASE) + 32'(issue_nxt);
    else
      addr_nxt = 32'(W_BASE) + 32'(issue_nxt) - 32'(HIDDEN);
  end

  // Strictly-greater replacement keeps the lowest index on ties.
  always_comb begin
    cand_wins = (fin_k == 4'd0) || (acc[fin_k] > best_score);
    nb_score  = cand_wins ? acc[fin_k] : best_score;
    nb_idx    = cand_wins ? fin_k : best_idx;
  end

  // NOTE: every register here uses <= so all updates see the pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      read_n    <= 1'b1;
      address   <= '0;
      doneSig   <= 1'b0;
      busy      <= 1'b0;
      digit     <= '0;
      max_score <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (startSig) begin
            // NOTE: act/acc are cleared at run start rather than on reset; no run
            // reads them before this clear, so a reset path would be dead logic.
            issue_cnt <= '0;
            rx_cnt    <= '0;
            w_cls     <= '0;
            w_in      <= '0;
            act       <= '0;
            for (int k = 0; k < CLASSES; k++) acc[k] <= '0;
            read_n    <= 1'b0;
            address   <= 32'(ACT_BASE);
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!waitrequest) begin
            issue_cnt <= issue_nxt;
            if (issue_cnt == CW'(N - 1)) begin
              read_n <= 1'b1;
              state  <= DRAIN;
            end else begin
              address <= addr_nxt;
            end
          end
        end
        DRAIN: begin
          if (rx_cnt == CW'(N)) begin
            fin_k <= '0;
            state <= FINAL;
          end
        end
        FINAL: begin
          best_score <= nb_score;
          best_idx   <= nb_idx;
          fin_k      <= fin_k + 1'b1;
          if (fin_k == 4'(CLASSES - 1)) begin
            digit     <= nb_idx;
            max_score <= nb_score;
            doneSig   <= 1'b1;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (!startSig) begin
            doneSig <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (rx_en) begin
        rx_cnt <= rx_cnt + 1'b1;
        if (rx_cnt < CW'(HIDDEN)) begin
          act[rx_cnt[IW-1:0]] <= (readdata != 16'd0);
        end else if (rx_cnt < CW'(W_END)) begin
          if (act[w_in]) acc[w_cls] <= acc[w_cls] + rd_ext;
          if (w_in == IW'(HIDDEN - 1)) begin
            w_in  <= '0;
            // Wrap to 0 after the last class so the bias phase reuses w_cls as its index.
            w_cls <= (w_cls == 4'(CLASSES - 1)) ? 4'd0 : w_cls + 1'b1;
          end else begin
            w_in <= w_in + 1'b1;
          end
        end else begin
          acc[w_cls] <= acc[w_cls] + rd_ext;
          w_cls      <= w_cls + 1'b1;
        end
      end
    end
  end

endmodule
